// File: rtl/cic_pkg.sv
// Shared helpers, default parameters and accumulator type for the
// dual-channel CIC decimator (cic_decimator_iq / cic_chan).
package cic_pkg;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned t;
    r = 0;
    t = (v > 0) ? v - 1 : 0;
    while (t > 0) begin
      r = r + 1;
      t = t >> 1;
    end
    return r;
  endfunction

  // Accumulator width that guarantees the final comb output never wraps:
  // IN_W + N*log2(R) for differential delay M=1.
  function automatic int unsigned acc_width(input int unsigned in_w,
                                            input int unsigned stages,
                                            input int unsigned decim);
    return in_w + stages * clog2(decim);
  endfunction

  localparam int unsigned STAGES_DEF = 3;
  localparam int unsigned DECIM_DEF  = 64;
  localparam int unsigned IN_W_DEF   = 8;
  localparam int unsigned OUT_W_DEF  = 12;
  localparam int unsigned ACC_W_DEF  = acc_width(IN_W_DEF, STAGES_DEF, DECIM_DEF);

  typedef logic signed [ACC_W_DEF-1:0] acc_t;

endpackage

// File: rtl/cic_chan.sv
// Single-channel CIC slice: integrator pipeline, strobed comb chain and
// registered output. Counter and strobe chain live in the parent.
// Optional build macro: CIC_ROUND_EN (round-half-up before truncation).
module cic_chan
  import cic_pkg::*;
#(
  parameter int unsigned STAGES = STAGES_DEF,
  parameter int unsigned DECIM  = DECIM_DEF,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  x_i,
  input  logic                    cap_i,
  input  logic [STAGES:0]         strb_i,
  output logic signed [OUT_W-1:0] y_o
);

  localparam int unsigned ACC_W = acc_width(IN_W, STAGES, DECIM);

  typedef logic signed [ACC_W-1:0] sacc_t;

`ifdef CIC_ROUND_EN
  localparam int unsigned RSH = (ACC_W > OUT_W) ? ACC_W - OUT_W - 1 : 0;
  localparam sacc_t       RND = (ACC_W > OUT_W) ? (sacc_t'(1) << RSH) : '0;
`else
  localparam sacc_t       RND = '0;
`endif

  sacc_t                    x_ext;
  sacc_t                    integ_q   [STAGES];
  sacc_t                    integ_d   [STAGES];
  sacc_t                    comb_in_q;
  sacc_t                    comb_in_d;
  sacc_t                    comb_src  [STAGES];
  sacc_t                    comb_q    [STAGES];
  sacc_t                    comb_d    [STAGES];
  sacc_t                    dly_q     [STAGES];
  sacc_t                    dly_d     [STAGES];
  sacc_t                    out_sum;
  logic signed [OUT_W-1:0]  y_q;
  logic signed [OUT_W-1:0]  y_d;

  // Integrator pipeline (free-running, modular) and decimated capture.
  always_comb begin
    x_ext      = {{(ACC_W-IN_W){x_i[IN_W-1]}}, x_i};
    integ_d[0] = integ_q[0] + x_ext;
    for (int unsigned k = 1; k < STAGES; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
    comb_in_d = cap_i ? integ_q[STAGES-1] : comb_in_q;
  end

  // Comb chain: stage k differences its input only while strobe k is high.
  always_comb begin
    comb_src[0] = comb_in_q;
    for (int unsigned k = 1; k < STAGES; k++) begin
      comb_src[k] = comb_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      comb_d[k] = comb_q[k];
      dly_d[k]  = dly_q[k];
      if (strb_i[k]) begin
        comb_d[k] = comb_src[k] - dly_q[k];
        dly_d[k]  = comb_src[k];
      end
    end
  end

  // Output: optional rounding offset, then keep the top OUT_W bits.
  always_comb begin
    out_sum = comb_q[STAGES-1] + RND;
    y_d     = strb_i[STAGES] ? OUT_W'(out_sum >>> (ACC_W - OUT_W)) : y_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
      comb_in_q <= '0;
      y_q       <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
        comb_q[k]  <= comb_d[k];
        dly_q[k]   <= dly_d[k];
      end
      comb_in_q <= comb_in_d;
      y_q       <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/cic_decimator_iq.sv
// Dual-channel (sin/cos) CIC decimator: shared decimation counter, strobe
// chain and valid pulse driving two identical cic_chan slices.
// Optional build macro: CIC_ROUND_EN (handled inside cic_chan).
module cic_decimator_iq
  import cic_pkg::*;
#(
  parameter int unsigned STAGES = STAGES_DEF,
  parameter int unsigned DECIM  = DECIM_DEF,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  MixerOutSin,
  input  logic signed [IN_W-1:0]  MixerOutCos,
  output logic signed [OUT_W-1:0] CICOutSin,
  output logic signed [OUT_W-1:0] CICOutCos,
  output logic                    CICOutValid
);

  localparam int unsigned CNT_W = clog2(DECIM);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cap;
  logic [STAGES:0]  strb_q;
  logic [STAGES:0]  strb_d;
  logic             valid_q;
  logic             valid_d;

  // Counter wraps naturally (DECIM is a power of two); capture on last count.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    cap     = (cnt_q == CNT_W'(DECIM - 1));
    strb_d  = {strb_q[STAGES-1:0], cap};
    valid_d = strb_q[STAGES];
  end

  // Counter, strobe shift register and valid pulse; reset kills in-flight strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      strb_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
      valid_q <= valid_d;
    end
  end

  cic_chan #(
    .STAGES(STAGES),
    .DECIM (DECIM),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sin (
    .clk   (clk),
    .rst   (rst),
    .x_i   (MixerOutSin),
    .cap_i (cap),
    .strb_i(strb_q),
    .y_o   (CICOutSin)
  );

  cic_chan #(
    .STAGES(STAGES),
    .DECIM (DECIM),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_cos (
    .clk   (clk),
    .rst   (rst),
    .x_i   (MixerOutCos),
    .cap_i (cap),
    .strb_i(strb_q),
    .y_o   (CICOutCos)
  );

  assign CICOutValid = valid_q;

endmodule
